// File: rtl/trig_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// trig_seq_ctrl_if
// Bundles the trigger controller's control, configuration and status signals.
//
// Modports:
//   master : the register block / stimulus side. Drives the trigger pin,
//            pulses and configuration, and observes status.
//   slave  : the trigger controller itself.
//
// Signals:
//   trig_in       raw asynchronous trigger pin
//   sw_trig       software trigger pulse, one clk
//   arm / disarm  arm and disarm request pulses
//   cfg_filt_len  debounce window (level must persist cfg_filt_len+1 cycles)
//   cfg_edge      00 rising, 01 falling, 1x both
//   cfg_holdoff   dead cycles after each fire, 0 = none
//   cfg_burst     triggers accepted per arm, 0 = unlimited
//   trig_out      single-cycle start pulse to playback
//   armed         high in ARMED or HOLDOFF
//   done          high in DONE
//   flt_level     debounced trigger level
//   trig_count    triggers fired since last arm
//   trig_ts       timestamp of the last fire (0 when timestamps are not built)
// -----------------------------------------------------------------------------
interface trig_seq_ctrl_if #(
    parameter int P_FLT_W  = 16,
    parameter int P_HOLD_W = 24,
    parameter int P_CNT_W  = 16
);
    logic                trig_in;
    logic                sw_trig;
    logic                arm;
    logic                disarm;
    logic [P_FLT_W-1:0]  cfg_filt_len;
    logic [1:0]          cfg_edge;
    logic [P_HOLD_W-1:0] cfg_holdoff;
    logic [P_CNT_W-1:0]  cfg_burst;
    logic                trig_out;
    logic                armed;
    logic                done;
    logic                flt_level;
    logic [P_CNT_W-1:0]  trig_count;
    logic [31:0]         trig_ts;

    modport master (
        output trig_in, sw_trig, arm, disarm,
        output cfg_filt_len, cfg_edge, cfg_holdoff, cfg_burst,
        input  trig_out, armed, done, flt_level, trig_count, trig_ts
    );

    modport slave (
        input  trig_in, sw_trig, arm, disarm,
        input  cfg_filt_len, cfg_edge, cfg_holdoff, cfg_burst,
        output trig_out, armed, done, flt_level, trig_count, trig_ts
    );
endinterface

// File: rtl/trig_seq_ctrl.sv
// -----------------------------------------------------------------------------
// trig_seq_ctrl
// Trigger-input controller for the AWG output path.
//
// A raw external trigger pin is synchronised through two flops, debounced by a
// runtime-programmable filter window, and edge-qualified. Qualified edges (or a
// software trigger) fire a single-cycle start pulse while the sequencer is
// ARMED. After each fire the sequencer may enter a blind HOLDOFF window, and
// after a programmed number of fires it parks in DONE until re-armed.
//
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   trig_seq_ctrl_if.slave (trigger pin, pulses, configuration, status)
//
// Build option:
//   TRIG_TIMESTAMP_EN  when defined, a 32-bit free-running counter is built
//                      and its value is captured into trig_ts on every fire.
//                      When undefined, trig_ts is tied to 0.
// -----------------------------------------------------------------------------
module trig_seq_ctrl #(
    parameter int P_FLT_W  = 16,
    parameter int P_HOLD_W = 24,
    parameter int P_CNT_W  = 16
) (
    input  logic           clk,
    input  logic           rst,
    trig_seq_ctrl_if.slave bus
);

    // Sequencer states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_HOLDOFF = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [P_FLT_W-1:0]  FLT_ZERO  = {P_FLT_W{1'b0}};
    localparam logic [P_FLT_W-1:0]  FLT_ONE   = {{(P_FLT_W-1){1'b0}}, 1'b1};
    localparam logic [P_HOLD_W-1:0] HOLD_ZERO = {P_HOLD_W{1'b0}};
    localparam logic [P_HOLD_W-1:0] HOLD_ONE  = {{(P_HOLD_W-1){1'b0}}, 1'b1};
    localparam logic [P_CNT_W-1:0]  CNT_ZERO  = {P_CNT_W{1'b0}};
    localparam logic [P_CNT_W-1:0]  CNT_ONE   = {{(P_CNT_W-1){1'b0}}, 1'b1};

    // Synchroniser and filter
    logic                s1_r;
    logic                s2_r;
    logic [P_FLT_W-1:0]  flt_cnt_r;
    logic                flt_level_r;
    logic                flt_d_r;

    // Edge qualification and fire
    logic                rise_s;
    logic                fall_s;
    logic                qual_edge_s;
    logic                fire_s;
    logic                arm_ok_s;
    logic                burst_hit_s;
    logic [P_CNT_W-1:0]  cnt_inc_s;

    // Sequencer
    logic [1:0]          state_r;
    logic [1:0]          state_nxt_s;
    logic [P_HOLD_W-1:0] hold_cnt_r;
    logic [P_HOLD_W-1:0] hold_nxt_s;

    // Configuration captured at the accepted arm
    logic [1:0]          edge_l_r;
    logic [P_HOLD_W-1:0] hold_l_r;
    logic [P_CNT_W-1:0]  burst_l_r;

    // Registered outputs
    logic                trig_out_r;
    logic                armed_r;
    logic                done_r;
    logic [P_CNT_W-1:0]  trig_count_r;

    // Two-flop synchroniser for the asynchronous trigger pin
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else begin
            s1_r <= bus.trig_in;
            s2_r <= s1_r;
        end
    end

    // Debounce filter: the synchronised level must differ from the current
    // debounced level for cfg_filt_len+1 consecutive samples before it is
    // adopted. Any agreeing sample restarts the window. The window length is
    // read live, so a change applies at the very next compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            flt_cnt_r   <= FLT_ZERO;
            flt_level_r <= 1'b0;
        end else if (s2_r == flt_level_r) begin
            flt_cnt_r   <= FLT_ZERO;
            flt_level_r <= flt_level_r;
        end else if (flt_cnt_r == bus.cfg_filt_len) begin
            flt_cnt_r   <= FLT_ZERO;
            flt_level_r <= s2_r;
        end else begin
            flt_cnt_r   <= flt_cnt_r + FLT_ONE;
            flt_level_r <= flt_level_r;
        end
    end

    // Delayed copy of the debounced level for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            flt_d_r <= 1'b0;
        end else begin
            flt_d_r <= flt_level_r;
        end
    end

    // Edge polarity match against the edge selection latched at arm time
    always_comb begin
        rise_s = flt_level_r & ~flt_d_r;
        fall_s = ~flt_level_r & flt_d_r;
        case (edge_l_r)
            2'b00:   qual_edge_s = rise_s;
            2'b01:   qual_edge_s = fall_s;
            default: qual_edge_s = rise_s | fall_s;
        endcase
    end

    // Fire / arm qualification. Disarm wins over both a fire and an arm in
    // the same cycle; an arm is only honoured from IDLE or DONE.
    always_comb begin
        fire_s      = (state_r == ST_ARMED) && (qual_edge_s || bus.sw_trig) && !bus.disarm;
        arm_ok_s    = bus.arm && !bus.disarm && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        cnt_inc_s   = trig_count_r + CNT_ONE;
        burst_hit_s = (burst_l_r != CNT_ZERO) && (cnt_inc_s == burst_l_r);
    end

    // Sequencer next-state and holdoff counter next value
    always_comb begin
        state_nxt_s = state_r;
        hold_nxt_s  = hold_cnt_r;
        if (bus.disarm) begin
            state_nxt_s = ST_IDLE;
            hold_nxt_s  = HOLD_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.arm) begin
                        state_nxt_s = ST_ARMED;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (fire_s) begin
                        if (burst_hit_s) begin
                            state_nxt_s = ST_DONE;
                        end else if (hold_l_r != HOLD_ZERO) begin
                            state_nxt_s = ST_HOLDOFF;
                            hold_nxt_s  = hold_l_r;
                        end else begin
                            state_nxt_s = ST_ARMED;
                        end
                    end else begin
                        state_nxt_s = ST_ARMED;
                    end
                end
                ST_HOLDOFF: begin
                    // Loaded with cfg_holdoff on the fire; leaving when it
                    // reads 1 gives exactly cfg_holdoff blind cycles.
                    if (hold_cnt_r == HOLD_ONE) begin
                        state_nxt_s = ST_ARMED;
                        hold_nxt_s  = HOLD_ZERO;
                    end else begin
                        state_nxt_s = ST_HOLDOFF;
                        hold_nxt_s  = hold_cnt_r - HOLD_ONE;
                    end
                end
                ST_DONE: begin
                    if (bus.arm) begin
                        state_nxt_s = ST_ARMED;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    hold_nxt_s  = HOLD_ZERO;
                end
            endcase
        end
    end

    // Sequencer state, holdoff counter and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= HOLD_ZERO;
            trig_out_r <= 1'b0;
            armed_r    <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            hold_cnt_r <= hold_nxt_s;
            trig_out_r <= fire_s;
            armed_r    <= (state_nxt_s == ST_ARMED) || (state_nxt_s == ST_HOLDOFF);
            done_r     <= (state_nxt_s == ST_DONE);
        end
    end

    // Fire counter: cleared on an accepted arm, wraps when burst is unlimited
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_count_r <= CNT_ZERO;
        end else if (arm_ok_s) begin
            trig_count_r <= CNT_ZERO;
        end else if (fire_s) begin
            trig_count_r <= cnt_inc_s;
        end else begin
            trig_count_r <= trig_count_r;
        end
    end

    // Configuration snapshot taken only on an accepted arm
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_l_r  <= 2'b00;
            hold_l_r  <= HOLD_ZERO;
            burst_l_r <= CNT_ZERO;
        end else if (arm_ok_s) begin
            edge_l_r  <= bus.cfg_edge;
            hold_l_r  <= bus.cfg_holdoff;
            burst_l_r <= bus.cfg_burst;
        end else begin
            edge_l_r  <= edge_l_r;
            hold_l_r  <= hold_l_r;
            burst_l_r <= burst_l_r;
        end
    end

`ifdef TRIG_TIMESTAMP_EN
    logic [31:0] ts_cnt_r;
    logic [31:0] trig_ts_r;

    // Free-running timestamp counter
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_cnt_r <= 32'd0;
        end else begin
            ts_cnt_r <= ts_cnt_r + 32'd1;
        end
    end

    // Capture the timestamp on the same edge that raises trig_out
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_ts_r <= 32'd0;
        end else if (fire_s) begin
            trig_ts_r <= ts_cnt_r;
        end else begin
            trig_ts_r <= trig_ts_r;
        end
    end

    assign bus.trig_ts = trig_ts_r;
`else
    assign bus.trig_ts = 32'd0;
`endif

    assign bus.trig_out   = trig_out_r;
    assign bus.armed      = armed_r;
    assign bus.done       = done_r;
    assign bus.flt_level  = flt_level_r;
    assign bus.trig_count = trig_count_r;

endmodule

// File: doc/trig_seq_ctrl.md
Name: trig_seq_ctrl

Overview:
- Trigger-input controller for the AWG output path.
- Synchronises and debounces a raw external trigger pin using a runtime-programmable filter window.
- Qualifies edges and sequences arm / fire / holdoff / burst-done states.
- Issues a single-cycle start pulse to the waveform playback engine. Also accepts a software trigger from the register block.

Parameters:
P_FLT_W, 16, width of filter-window counter and cfg_filt_len
P_HOLD_W, 24, width of holdoff counter and cfg_holdoff
P_CNT_W, 16, width of burst length and trigger counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
trig_in  in  1  raw asynchronous trigger pin
sw_trig  in  1  software trigger pulse, one clk
arm  in  1  arm request pulse
disarm  in  1  disarm request pulse
cfg_filt_len  in  P_FLT_W  filter window; level must persist cfg_filt_len+1 cycles
cfg_edge  in  2  00 rising, 01 falling, 1x both
cfg_holdoff  in  P_HOLD_W  dead cycles after each fire; 0 = none
cfg_burst  in  P_CNT_W  triggers accepted per arm; 0 = unlimited
trig_out  out  1  start pulse to playback, one clk
armed  out  1  high in ARMED or HOLDOFF
done  out  1  high in DONE
flt_level  out  1  debounced trigger level
trig_count  out  P_CNT_W  triggers fired since last arm
trig_ts  out  32  timestamp of last fire (see Optional Feature)

Behaviour:
- Reset values: all outputs 0. Synchroniser, filter counter, FSM (IDLE) and holdoff counter cleared.
- Synchroniser: 2-FF chain s1 -> s2.
- Filter, runs continuously, independent of FSM:
  - if s2 == flt_level, cnt <= 0;
  - else if cnt == cfg_filt_len, flt_level <= s2 and cnt <= 0;
  - else cnt <= cnt+1.
  - cfg_filt_len is used live; changing it mid-count takes effect on the next compare.
- Edge detect: flt_d registers flt_level; qualified edge = flt_level != flt_d, matched against cfg_edge.
- Latency: trig_in edge to trig_out high = cfg_filt_len+4 clk. Pulses shorter than cfg_filt_len+1 clk produce no edge.
- Config latch: cfg_edge, cfg_holdoff and cfg_burst are latched on an accepted arm and held until the next accepted arm.
- fire = (qualified edge OR sw_trig) while in ARMED. Simultaneous edge and sw_trig count as one fire.
- FSM states IDLE, ARMED, HOLDOFF, DONE:
  - IDLE: arm -> ARMED; trig_count <= 0.
  - ARMED, on fire: trig_out <= 1 next cycle and trig_count <= trig_count+1. Then:
    - if burst != 0 and trig_count+1 == burst -> DONE;
    - else if holdoff != 0 -> HOLDOFF, load hold_cnt = holdoff;
    - else stay ARMED (back-to-back fires allowed).
  - HOLDOFF: hold_cnt decrements; edges and sw_trig are dropped, not queued. At hold_cnt == 1 -> ARMED. Exactly cfg_holdoff cycles are blind.
  - DONE: done = 1, trig_count holds. arm -> ARMED with trig_count <= 0.
- disarm: from any state -> IDLE next cycle. Has priority over a simultaneous fire (no trig_out, no count) and over a simultaneous arm.
- arm while in ARMED or HOLDOFF: ignored; latched config unchanged.
- trig_count with unlimited burst: wraps from all-ones to 0.
- rst mid-operation: immediate return to reset values. A trig_out pulse in progress is cut.

Optional Feature:
- Macro TRIG_TIMESTAMP_EN.
- Defined:
  - 32-bit free-running counter, reset to 0, wraps.
  - On each fire, its value is registered into trig_ts, updating in the same cycle trig_out goes high.
- Undefined: no counter is built and trig_ts is tied to 0.

Test Plan:
- filt_len=3, arm, trig_in 0->1 held 10 clk, edge=00 -> one trig_out exactly 7 clk after the trig_in change; trig_count=1.
- filt_len=3, trig_in high-pulses of 3 clk -> flt_level stays 0, no trig_out. A 4-clk pulse -> flt_level rises and trig_out fires once.
- burst=3, holdoff=0, sw_trig every 2 clk -> three trig_out pulses, done=1, trig_count=3. Fourth sw_trig ignored. arm -> trig_count=0, armed=1.
- holdoff=20, edge=1x, trig_in edges 5 clk apart after filtering -> fire on first edge; edges inside the 20-cycle window are dropped; the next edge after the window fires.
- disarm and sw_trig in the same cycle while ARMED -> no trig_out, state IDLE, trig_count unchanged. arm and disarm together from IDLE -> stays IDLE.
- TRIG_TIMESTAMP_EN defined: fires at timestamps 100 and 250 -> trig_ts reads 100 then 250. Undefined: trig_ts=0 throughout.
